// File: rtl/counter_cmd_sched_if.sv
// rtl/counter_cmd_sched_if.sv - request/status bundle between host endpoints and counter_cmd_sched
interface counter_cmd_sched_if;
  logic       clr_req;
  logic       up_req;
  logic       down_req;
  logic       auto_en;
  logic       burst_req;
  logic [7:0] burst_len;
  logic [7:0] count;
  logic       wrap_up;
  logic       wrap_dn;
  logic       pend_ovf;
  logic       busy;
  logic       burst_busy;

  modport master (
    output clr_req, up_req, down_req, auto_en, burst_req, burst_len,
    input  count, wrap_up, wrap_dn, pend_ovf, busy, burst_busy
  );

  modport slave (
    input  clr_req, up_req, down_req, auto_en, burst_req, burst_len,
    output count, wrap_up, wrap_dn, pend_ovf, busy, burst_busy
  );
endinterface

// File: rtl/counter_cmd_sched.sv
// rtl/counter_cmd_sched.sv - 8-bit event counter command scheduler; burst engine gated by COUNTER_SCHED_BURST_EN
module counter_cmd_sched #(
  parameter int                   DIV_WIDTH  = 24,
  parameter logic [DIV_WIDTH-1:0] DIV_RELOAD = 24'h100000,
  parameter int                   PEND_WIDTH = 4
) (
  input logic                ti_clk,
  input logic                reset,
  counter_cmd_sched_if.slave bus
);

  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [PEND_WIDTH-1:0] PEND_ONE = {{(PEND_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [PEND_WIDTH-1:0] pend_up;
  logic [PEND_WIDTH-1:0] pend_dn;
  logic [DIV_WIDTH-1:0]  div;
  logic                  auto_pend;
  logic [7:0]            cnt;
  logic                  wrap_up;
  logic                  wrap_dn;
  logic                  pend_ovf;
  logic                  burst_run;

  logic iss_dn, iss_up, iss_burst, iss_auto, iss_inc;
  logic acc_up, acc_dn, ovf_up, ovf_dn;

  // Fixed-priority pick among registered pending sources (clear is handled separately, it overrides all)
  always_comb begin
    iss_dn    = (pend_dn != '0);
    iss_up    = !iss_dn && (pend_up != '0);
    iss_burst = !iss_dn && !iss_up && burst_run;
    iss_auto  = !iss_dn && !iss_up && !burst_run && auto_pend;
    iss_inc   = iss_up || iss_burst || iss_auto;
    // A request at a full counter is still accepted if the same counter issues this cycle
    ovf_up    = bus.up_req   && (pend_up == PEND_MAX) && !iss_up;
    ovf_dn    = bus.down_req && (pend_dn == PEND_MAX) && !iss_dn;
    acc_up    = bus.up_req   && !ovf_up;
    acc_dn    = bus.down_req && !ovf_dn;
  end

  // Pending up/down counters and the sticky overflow flag
  always_ff @(posedge ti_clk) begin
    if (reset || bus.clr_req) begin
      pend_up  <= '0;
      pend_dn  <= '0;
      pend_ovf <= 1'b0;
    end else begin
      if (acc_up && !iss_up)      pend_up <= pend_up + PEND_ONE;
      else if (!acc_up && iss_up) pend_up <= pend_up - PEND_ONE;
      if (acc_dn && !iss_dn)      pend_dn <= pend_dn + PEND_ONE;
      else if (!acc_dn && iss_dn) pend_dn <= pend_dn - PEND_ONE;
      if (ovf_up || ovf_dn)       pend_ovf <= 1'b1;
    end
  end

  // Autocount divider; ticks coalesce into a single pending flag
  always_ff @(posedge ti_clk) begin
    if (reset || !bus.auto_en) begin
      div       <= DIV_RELOAD;
      auto_pend <= 1'b0;
    end else begin
      if (div == '0) div <= DIV_RELOAD;
      else           div <= div - DIV_ONE;
      if (bus.clr_req)    auto_pend <= 1'b0;
      else if (div == '0) auto_pend <= 1'b1;
      else if (iss_auto)  auto_pend <= 1'b0;
    end
  end

  // Counter update with wrap pulses registered alongside the new value
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      cnt     <= 8'd0;
      wrap_up <= 1'b0;
      wrap_dn <= 1'b0;
    end else begin
      wrap_up <= 1'b0;
      wrap_dn <= 1'b0;
      if (bus.clr_req) begin
        cnt <= 8'd0;
      end else if (iss_dn) begin
        cnt     <= cnt - 8'd1;
        wrap_dn <= (cnt == 8'h00);
      end else if (iss_inc) begin
        cnt     <= cnt + 8'd1;
        wrap_up <= (cnt == 8'hFF);
      end
    end
  end

`ifdef COUNTER_SCHED_BURST_EN
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0] state;
  logic [7:0] remaining;

  // Burst engine: load length on request, retire one increment per won slot
  always_ff @(posedge ti_clk) begin
    if (reset || bus.clr_req) begin
      state     <= ST_IDLE;
      remaining <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.burst_req && (bus.burst_len != 8'd0)) begin
            state     <= ST_RUN;
            remaining <= bus.burst_len;
          end
        end
        default: begin
          if (iss_burst) begin
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign burst_run = (state == ST_RUN);
`else
  logic unused_burst;
  assign unused_burst = ^{bus.burst_req, bus.burst_len};
  assign burst_run    = 1'b0;
`endif

  assign bus.count      = cnt;
  assign bus.wrap_up    = wrap_up;
  assign bus.wrap_dn    = wrap_dn;
  assign bus.pend_ovf   = pend_ovf;
  assign bus.burst_busy = burst_run;
  assign bus.busy       = (pend_up != '0) || (pend_dn != '0) || auto_pend || burst_run;

endmodule

// File: tb/tb_counter_cmd_sched.sv
// tb/tb_counter_cmd_sched.sv - scoreboard bench for counter_cmd_sched
module tb_counter_cmd_sched;

  logic ti_clk = 1'b0;
  logic reset  = 1'b1;
  always #5 ti_clk = ~ti_clk;

  counter_cmd_sched_if bus();

  counter_cmd_sched #(
    .DIV_WIDTH (24),
    .DIV_RELOAD(24'd3),
    .PEND_WIDTH(4)
  ) dut (
    .ti_clk(ti_clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] cnt;
    logic       wu;
    logic       wd;
  } exp_t;

  exp_t       sb[$];
  exp_t       e_mon;
  int         passed = 0;
  int         total  = 0;
  logic [7:0] prev_count = 8'd0;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  task automatic push(input logic [7:0] c, input logic wu, input logic wd);
    exp_t e;
    e.cnt = c;
    e.wu  = wu;
    e.wd  = wd;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge ti_clk);
    #1;
  endtask

  // Monitor: every change of count must match the next queued expectation
  always @(negedge ti_clk) begin
    if (reset) begin
      prev_count = bus.count;
    end else if (bus.count !== prev_count) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: count became 0x%0h, expected no change", bus.count);
      end else begin
        e_mon = sb.pop_front();
        check("sb_count",   int'(bus.count),   int'(e_mon.cnt));
        check("sb_wrap_up", int'(bus.wrap_up), int'(e_mon.wu));
        check("sb_wrap_dn", int'(bus.wrap_dn), int'(e_mon.wd));
      end
      prev_count = bus.count;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clr_req   = 1'b0;
    bus.up_req    = 1'b0;
    bus.down_req  = 1'b0;
    bus.auto_en   = 1'b0;
    bus.burst_req = 1'b0;
    bus.burst_len = 8'd0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_count",      int'(bus.count),      0);
    check("rst_busy",       int'(bus.busy),       0);
    check("rst_pend_ovf",   int'(bus.pend_ovf),   0);
    check("rst_wrap",       int'({bus.wrap_up, bus.wrap_dn}), 0);
    check("rst_burst_busy", int'(bus.burst_busy), 0);
    reset = 1'b0;

    // Three consecutive up pulses
    push(8'd1, 0, 0); push(8'd2, 0, 0); push(8'd3, 0, 0);
    bus.up_req = 1'b1;
    tick(); check("up3_e1", int'(bus.count), 0);
    tick(); check("up3_e2", int'(bus.count), 1);
    tick(); check("up3_e3", int'(bus.count), 2);
    bus.up_req = 1'b0;
    tick(); check("up3_e4", int'(bus.count), 3);
    check("up3_busy", int'(bus.busy), 0);

    // Bring count to 5, then simultaneous up and down
    push(8'd4, 0, 0); push(8'd5, 0, 0);
    bus.up_req = 1'b1;
    tick(); tick();
    bus.up_req = 1'b0;
    tick();
    check("to5", int'(bus.count), 5);
    push(8'd4, 0, 0); push(8'd5, 0, 0);
    bus.up_req = 1'b1; bus.down_req = 1'b1;
    tick();
    bus.up_req = 1'b0; bus.down_req = 1'b0;
    tick(); check("ud_down_first", int'(bus.count), 4);
    tick(); check("ud_up_second",  int'(bus.count), 5);
    tick(); check("ud_final",      int'(bus.count), 5);
    check("ud_busy", int'(bus.busy), 0);

    // Clear, then wrap down / up / down
    push(8'd0, 0, 0);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    check("clr_count", int'(bus.count), 0);
    push(8'hFF, 0, 1);
    bus.down_req = 1'b1; tick(); bus.down_req = 1'b0;
    tick(); check("wrapdn_pulse", int'(bus.wrap_dn), 1);
    tick(); check("wrapdn_clear", int'(bus.wrap_dn), 0);
    push(8'h00, 1, 0);
    bus.up_req = 1'b1; tick(); bus.up_req = 1'b0;
    tick(); check("wrapup_pulse", int'(bus.wrap_up), 1);
    tick(); check("wrapup_clear", int'(bus.wrap_up), 0);
    push(8'hFF, 0, 1);
    bus.down_req = 1'b1; tick(); bus.down_req = 1'b0;
    tick(); check("wrapdn2_count", int'(bus.count), 'hFF);

    // Pending saturation: down holds priority so up requests pile up
    for (int i = 1; i <= 16; i++) push(8'hFF - 8'(i), 0, 0);
    push(8'h00, 0, 0);
    bus.up_req = 1'b1; bus.down_req = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      tick();
      if (k == 14) check("ovf_before", int'(bus.pend_ovf), 0);
      if (k == 15) check("ovf_set",    int'(bus.pend_ovf), 1);
    end
    check("ovf_busy", int'(bus.busy), 1);
    bus.up_req = 1'b0; bus.down_req = 1'b0; bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    check("ovf_clr_count", int'(bus.count),    0);
    check("ovf_clr_flag",  int'(bus.pend_ovf), 0);
    check("ovf_clr_busy",  int'(bus.busy),     0);

    // Idle autocount with reload 3: one increment every 4 cycles
    push(8'd1, 0, 0); push(8'd2, 0, 0); push(8'd3, 0, 0);
    bus.auto_en = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      tick();
      if (i == 3) check("auto_e3", int'(bus.count), 0);
      if (i == 4) check("auto_e4", int'(bus.count), 1);
      if (i == 7) check("auto_e7", int'(bus.count), 1);
      if (i == 8) check("auto_e8", int'(bus.count), 2);
    end
    check("auto_e12", int'(bus.count), 3);
    bus.auto_en = 1'b0;
    tick();
    check("auto_off_busy", int'(bus.busy), 0);

    // Autocount coalesces under a continuous stream of up requests
    for (int i = 4; i <= 13; i++) push(8'(i), 0, 0);
    bus.auto_en = 1'b1; bus.up_req = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("coal_mid", int'(bus.count), 12);
    bus.auto_en = 1'b0; bus.up_req = 1'b0;
    tick(); check("coal_last", int'(bus.count), 13);
    tick(); check("coal_final", int'(bus.count), 13);
    check("coal_busy", int'(bus.busy), 0);
    check("coal_ovf",  int'(bus.pend_ovf), 0);

`ifdef COUNTER_SCHED_BURST_EN
    // Zero-length burst is ignored
    bus.burst_req = 1'b1; bus.burst_len = 8'd0;
    tick();
    bus.burst_req = 1'b0;
    check("burst0_busy", int'(bus.burst_busy), 0);
    // Burst of 4 with a down request stealing one slot
    push(8'd14, 0, 0); push(8'd13, 0, 0); push(8'd14, 0, 0); push(8'd15, 0, 0); push(8'd16, 0, 0);
    bus.burst_req = 1'b1; bus.burst_len = 8'd4;
    tick();
    bus.burst_req = 1'b0; bus.down_req = 1'b1;
    check("burst_start", int'(bus.burst_busy), 1);
    tick();
    bus.down_req = 1'b0;
    check("burst_c1", int'(bus.count), 14);
    tick(); check("burst_c2_down", int'(bus.count), 13);
    tick(); tick();
    check("burst_c4", int'(bus.count), 15);
    check("burst_c4_busy", int'(bus.burst_busy), 1);
    tick();
    check("burst_end_count", int'(bus.count), 16);
    check("burst_end_busy",  int'(bus.burst_busy), 0);
    check("burst_end_all",   int'(bus.busy), 0);
`else
    // Burst inputs have no effect without the burst engine
    bus.burst_req = 1'b1; bus.burst_len = 8'd4;
    tick();
    bus.burst_req = 1'b0;
    tick(); tick();
    check("noburst_count", int'(bus.count), 13);
    check("noburst_busy",  int'(bus.burst_busy), 0);
    check("noburst_all",   int'(bus.busy), 0);
`endif

    tick(); tick();
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
